muovi_quadrato: RTL and testbench

//  Sequential position controller for the on-screen square. Produces centre X_POS/Y_POS consumed by the

---
 rtl/muovi_quadrato_if.sv | 24 ++
 rtl/muovi_quadrato.sv | 144 ++++++++++++++
 tb/tb_muovi_quadrato.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/muovi_quadrato_if.sv
// Button/frame inputs and position outputs of the square controller.
// master: frame/button source; slave: muovi_quadrato.
interface muovi_quadrato_if;
   logic        FRAME_TICK;
   logic        SU;
   logic        GIU;
   logic        SINISTRA;
   logic        DESTRA;
   logic        PAUSA;
   logic [10:0] X_POS;
   logic [10:0] Y_POS;
   logic        IN_MOTO;
   logic        BORDO;

   modport master (
      output FRAME_TICK, SU, GIU, SINISTRA, DESTRA, PAUSA,
      input  X_POS, Y_POS, IN_MOTO, BORDO
   );

   modport slave (
      input  FRAME_TICK, SU, GIU, SINISTRA, DESTRA, PAUSA,
      output X_POS, Y_POS, IN_MOTO, BORDO
   );
endinterface

// File: rtl/muovi_quadrato.sv
// Per-frame position controller for the on-screen square.
// Ports: CLK, RST_N (async low); bus (slave): FRAME_TICK, SU/GIU/SINISTRA/DESTRA/PAUSA
// buttons in, X_POS/Y_POS centre, IN_MOTO, BORDO out. Define RIMBALZO_EN for Y bounce.
module muovi_quadrato #(
   parameter int H         = 1280,
   parameter int V         = 1024,
   parameter int ALTEZZA   = 100,
   parameter int X_INIT    = 640,
   parameter int Y_INIT    = 512,
   parameter int PASSO_MAX = 7
) (
   input  logic              CLK,
   input  logic              RST_N,
   muovi_quadrato_if.slave   bus
);

   localparam int YMIN = ALTEZZA / 2;
   localparam int YMAX = V - 1 - ALTEZZA / 2;

   localparam logic signed [3:0]  PMAX   = 4'(PASSO_MAX);
   localparam logic signed [11:0] H_S    = 12'(H);
   localparam logic signed [11:0] YMIN_S = 12'(YMIN);
   localparam logic signed [11:0] YMAX_S = 12'(YMAX);

   typedef enum logic {ATTIVO, PAUSA_ST} stato_t;

   stato_t stato, stato_n;

   // Button bits: {PAUSA, DESTRA, SINISTRA, GIU, SU}
   logic [4:0] sync1, sync2;
   logic       pausa_q;
   logic       pausa_edge;
   logic       applica;

   logic signed [3:0] vx, vy;
   logic signed [3:0] vx_n, vy_n0, vy_f;
   logic signed [11:0] tx, ty;
   logic [10:0] x, y, x_n, y_n;
   logic        in_moto, bordo, hit;

   // Accelerate toward the pressed direction, brake toward 0 otherwise.
   function automatic logic signed [3:0] nuova_vel(
      input logic signed [3:0] v,
      input logic              piu,
      input logic              meno
   );
      logic signed [3:0] r;
      if (piu && !meno)
         r = (v >= PMAX) ? PMAX : v + 4'sd1;
      else if (meno && !piu)
         r = (v <= -PMAX) ? -PMAX : v - 4'sd1;
      else if (v > 4'sd0)
         r = v - 4'sd1;
      else if (v < 4'sd0)
         r = v + 4'sd1;
      else
         r = 4'sd0;
      return r;
   endfunction

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         sync1   <= '0;
         sync2   <= '0;
         pausa_q <= 1'b0;
      end else begin
         sync1   <= {bus.PAUSA, bus.DESTRA, bus.SINISTRA,
                     bus.GIU, bus.SU};
         sync2   <= sync1;
         pausa_q <= sync2[4];
      end
   end

   assign pausa_edge = sync2[4] & ~pausa_q;

   // A pause toggle in the same cycle as a tick swallows the tick.
   assign applica = bus.FRAME_TICK && (stato == ATTIVO) && !pausa_edge;

   always_comb begin
      stato_n = stato;
      if (pausa_edge) begin
         case (stato)
            ATTIVO:   stato_n = PAUSA_ST;
            PAUSA_ST: stato_n = ATTIVO;
            default:  stato_n = ATTIVO;
         endcase
      end
   end

   always_comb begin
      vx_n  = nuova_vel(vx, sync2[3], sync2[2]);
      vy_n0 = nuova_vel(vy, sync2[1], sync2[0]);
      vy_f  = vy_n0;
      hit   = 1'b0;

      tx = $signed({1'b0, x}) + {{8{vx_n[3]}}, vx_n};
      if (tx >= H_S)
         tx = tx - H_S;
      else if (tx < 12'sd0)
         tx = tx + H_S;
      x_n = tx[10:0];

      ty  = $signed({1'b0, y}) + {{8{vy_n0[3]}}, vy_n0};
      y_n = ty[10:0];
      if (ty < YMIN_S || ty > YMAX_S) begin
         hit = 1'b1;
         y_n = (ty < YMIN_S) ? YMIN_S[10:0] : YMAX_S[10:0];
`ifdef RIMBALZO_EN
         vy_f = -vy_n0;
`else
         vy_f = 4'sd0;
`endif
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         stato   <= ATTIVO;
         x       <= 11'(X_INIT);
         y       <= 11'(Y_INIT);
         vx      <= 4'sd0;
         vy      <= 4'sd0;
         in_moto <= 1'b0;
         bordo   <= 1'b0;
      end else begin
         stato <= stato_n;
         bordo <= 1'b0;
         if (applica) begin
            x       <= x_n;
            y       <= y_n;
            vx      <= vx_n;
            vy      <= vy_f;
            in_moto <= (vx_n != 4'sd0) || (vy_f != 4'sd0);
            bordo   <= hit;
         end
      end
   end

   assign bus.X_POS   = x;
   assign bus.Y_POS   = y;
   assign bus.IN_MOTO = in_moto;
   assign bus.BORDO   = bordo;

endmodule

// File: tb/tb_muovi_quadrato.sv
// Directed bench for muovi_quadrato: motion, wrap, clamp, pause, reset.
// Expected values are hand-computed from the default parameters.
module tb_muovi_quadrato;

   logic CLK;
   logic RST_N;
   int   errors;
   int   checks;

   muovi_quadrato_if bus ();

   muovi_quadrato dut (
      .CLK   (CLK),
      .RST_N (RST_N),
      .bus   (bus.slave)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [15:0] obs,
                      input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic botoni(input logic su, input logic giu,
                         input logic sx, input logic dx);
      bus.SU       = su;
      bus.GIU      = giu;
      bus.SINISTRA = sx;
      bus.DESTRA   = dx;
      repeat (4) @(negedge CLK);
   endtask

   task automatic tick();
      bus.FRAME_TICK = 1'b1;
      @(negedge CLK);
      bus.FRAME_TICK = 1'b0;
   endtask

   task automatic ticks(input int n);
      for (int k = 0; k < n; k++) begin
         tick();
         @(negedge CLK);
      end
   endtask

   task automatic pulse_pausa();
      bus.PAUSA = 1'b1;
      repeat (4) @(negedge CLK);
      bus.PAUSA = 1'b0;
      repeat (4) @(negedge CLK);
   endtask

   task automatic do_reset();
      bus.FRAME_TICK = 1'b0;
      bus.SU         = 1'b0;
      bus.GIU        = 1'b0;
      bus.SINISTRA   = 1'b0;
      bus.DESTRA     = 1'b0;
      bus.PAUSA      = 1'b0;
      RST_N          = 1'b0;
      repeat (3) @(negedge CLK);
      RST_N = 1'b1;
      @(negedge CLK);
   endtask

   int exp_acc [10] = '{641, 643, 646, 650, 655, 661, 668, 675, 682, 689};
   int exp_brk [7]  = '{695, 700, 704, 707, 709, 710, 710};

   initial begin
      errors = 0;
      checks = 0;

      // Reset state and idle ticks
      do_reset();
      chk("rst_x", bus.X_POS, 16'd640);
      chk("rst_y", bus.Y_POS, 16'd512);
      chk("rst_moto", bus.IN_MOTO, 16'd0);
      chk("rst_bordo", bus.BORDO, 16'd0);
      ticks(5);
      chk("idle_x", bus.X_POS, 16'd640);
      chk("idle_y", bus.Y_POS, 16'd512);

      // Acceleration then braking
      botoni(0, 0, 0, 1);
      for (int i = 0; i < 10; i++) begin
         tick();
         chk($sformatf("acc_x%0d", i), bus.X_POS, 16'(exp_acc[i]));
         chk($sformatf("acc_m%0d", i), bus.IN_MOTO, 16'd1);
         @(negedge CLK);
      end
      botoni(0, 0, 0, 0);
      for (int i = 0; i < 7; i++) begin
         tick();
         chk($sformatf("brk_x%0d", i), bus.X_POS, 16'(exp_brk[i]));
         chk($sformatf("brk_m%0d", i), bus.IN_MOTO,
             (i == 6) ? 16'd0 : 16'd1);
         @(negedge CLK);
      end
      repeat (20) @(negedge CLK);
      chk("hold_x", bus.X_POS, 16'd710);

      // Opposite buttons brake
      do_reset();
      botoni(0, 0, 0, 1);
      ticks(3);
      chk("opp_start", bus.X_POS, 16'd646);
      botoni(0, 0, 1, 1);
      tick();
      chk("opp_x0", bus.X_POS, 16'd648);
      @(negedge CLK);
      tick();
      chk("opp_x1", bus.X_POS, 16'd649);
      @(negedge CLK);
      tick();
      chk("opp_x2", bus.X_POS, 16'd649);
      chk("opp_moto", bus.IN_MOTO, 16'd0);
      @(negedge CLK);

      // Right wrap
      do_reset();
      botoni(0, 0, 0, 1);
      ticks(94);
      chk("wrapr_pre", bus.X_POS, 16'd1277);
      tick();
      chk("wrapr", bus.X_POS, 16'd4);
      @(negedge CLK);

      // Left wrap
      do_reset();
      botoni(0, 0, 1, 0);
      ticks(94);
      chk("wrapl_pre", bus.X_POS, 16'd3);
      tick();
      chk("wrapl", bus.X_POS, 16'd1276);
      @(negedge CLK);

      // Bottom limit
      do_reset();
      botoni(0, 1, 0, 0);
      ticks(68);
      chk("ymax_pre", bus.Y_POS, 16'd967);
      tick();
      chk("ymax_y", bus.Y_POS, 16'd973);
      chk("ymax_bordo", bus.BORDO, 16'd1);
`ifdef RIMBALZO_EN
      chk("ymax_moto", bus.IN_MOTO, 16'd1);
`else
      chk("ymax_moto", bus.IN_MOTO, 16'd0);
`endif
      @(negedge CLK);
      chk("ymax_bordo_end", bus.BORDO, 16'd0);
      tick();
`ifdef RIMBALZO_EN
      chk("ymax_y2", bus.Y_POS, 16'd967);
      chk("ymax_bordo2", bus.BORDO, 16'd0);
`else
      chk("ymax_y2", bus.Y_POS, 16'd973);
      chk("ymax_bordo2", bus.BORDO, 16'd1);
`endif
      @(negedge CLK);

      // Top limit: landing exactly on YMIN is not a hit
      do_reset();
      botoni(1, 0, 0, 0);
      ticks(68);
      tick();
      chk("ymin_exact", bus.Y_POS, 16'd50);
      chk("ymin_nobordo", bus.BORDO, 16'd0);
      @(negedge CLK);
      tick();
      chk("ymin_y", bus.Y_POS, 16'd50);
      chk("ymin_bordo", bus.BORDO, 16'd1);
      @(negedge CLK);

      // Pause freezes, resume keeps speed
      do_reset();
      botoni(0, 0, 0, 1);
      ticks(3);
      chk("pz_start", bus.X_POS, 16'd646);
      pulse_pausa();
      for (int i = 0; i < 4; i++) begin
         tick();
         chk($sformatf("pz_x%0d", i), bus.X_POS, 16'd646);
         @(negedge CLK);
      end
      chk("pz_moto", bus.IN_MOTO, 16'd1);
      pulse_pausa();
      tick();
      chk("pz_resume", bus.X_POS, 16'd650);
      @(negedge CLK);

      // Pause edge coincident with tick: tick dropped
      bus.PAUSA = 1'b1;
      @(posedge CLK);
      @(posedge CLK);
      @(negedge CLK);
      tick();
      chk("coinc_x", bus.X_POS, 16'd650);
      @(negedge CLK);
      tick();
      chk("coinc_paused", bus.X_POS, 16'd650);
      @(negedge CLK);
      bus.PAUSA = 1'b0;
      repeat (4) @(negedge CLK);
      pulse_pausa();
      tick();
      chk("coinc_resume", bus.X_POS, 16'd655);
      @(negedge CLK);

      // Asynchronous reset mid-frame
      #3;
      RST_N = 1'b0;
      #1;
      chk("arst_x", bus.X_POS, 16'd640);
      chk("arst_y", bus.Y_POS, 16'd512);
      chk("arst_moto", bus.IN_MOTO, 16'd0);
      chk("arst_bordo", bus.BORDO, 16'd0);
      @(negedge CLK);
      RST_N = 1'b1;
      @(negedge CLK);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
